m92_cpu_bus_ctrl: RTL and testbench

//  Sequences the V30 main CPU's accesses to the shared SDRAM ROM/RAM port and owns CPU clock-enable gating.

---
 rtl/m92_pkg.sv | 22 ++
 rtl/m92_ce_gate.sv | 37 +++
 rtl/m92_cpu_bus_ctrl.sv | 118 +++++++++++
 tb/tb_m92_cpu_bus_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m92_pkg.sv
// Shared types and helpers for the M92 main-CPU bus controller.
// Byte-lane helpers map the V30's odd/even byte addressing onto the 16-bit SDRAM word.
package m92_pkg;

    typedef enum logic [1:0] {IDLE, REQ, PAUSED} cpu_bus_state_t;

    localparam int CPU_CE_DIV = 4;

    // Odd byte reads come from the high lane of the stored word
    function automatic logic [15:0] word_shuffle_rd(input logic odd, input logic [15:0] d);
        return odd ? {8'h00, d[15:8]} : d;
    endfunction

    function automatic logic [15:0] word_shuffle_wr(input logic odd, input logic [15:0] d);
        return odd ? {d[7:0], 8'h00} : d;
    endfunction

    function automatic logic [1:0] byte_sel(input logic odd, input logic [1:0] be);
        return odd ? {be[0], 1'b0} : be;
    endfunction

endpackage

// File: rtl/m92_ce_gate.sv
// CPU clock-enable generator: a modulo-CE_DIV counter that only advances when
// nothing is stalling the CPU; every advance is a ce_4x pulse, every wrap a ce pulse.
module m92_ce_gate #(
    parameter int CE_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic mem_strobe,
    input  logic rq_active,
    input  logic ext_busy,
    input  logic paused_st,
    output logic ce_cpu,
    output logic ce_4x_cpu
);

    localparam int CW = $clog2(CE_DIV);

    logic [CW-1:0] cnt;
    logic          stall;

    assign stall = mem_strobe | rq_active | ext_busy | paused_st;

    // CE_DIV is a power of two, so the counter wraps by overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            ce_cpu    <= 1'b0;
            ce_4x_cpu <= 1'b0;
        end else begin
            ce_4x_cpu <= ~stall;
            ce_cpu    <= ~stall && (cnt == CW'(CE_DIV - 1));
            if (!stall)
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/m92_cpu_bus_ctrl.sv
// V30 bus sequencer: turns single-cycle bus strobes into toggle-handshake SDRAM
// requests, stalls the CPU clock enable while busy and handles frame-exact pause.
module m92_cpu_bus_ctrl
    import m92_pkg::*;
#(
    parameter int CE_DIV = CPU_CE_DIV,
    parameter int SDR_AW = 25
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pause_rq,
    input  logic [8:0]        v_count,
    input  logic [9:0]        h_count,
    output logic              paused,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [19:0]       cpu_addr,
    input  logic [1:0]        cpu_be,
    input  logic [15:0]       cpu_dout,
    output logic [15:0]       cpu_rd_data,
    input  logic              region_memrq,
    input  logic [SDR_AW-1:0] region_addr,
    input  logic              region_writable,
    input  logic              ext_busy,
    output logic              ce_cpu,
    output logic              ce_4x_cpu,
    output logic              rq_active,
    output logic              sdr_rq,
    input  logic              sdr_ack,
    output logic [SDR_AW-1:0] sdr_addr,
    output logic [15:0]       sdr_din,
    output logic [1:0]        sdr_wr_sel,
    input  logic [15:0]       sdr_dout
);

    cpu_bus_state_t state;
    logic           rd_lat, wr_lat;
    logic           launch_rd, launch_wr, strobe;
    logic [15:0]    data;
    logic [8:0]     pause_v;
    logic [9:0]     pause_h;
    logic           unused_addr;

    // Strobes are stretched to two cycles so the stall covers the gap before rq_active rises
    assign launch_rd   = cpu_rd & ~rd_lat;
    assign launch_wr   = cpu_wr & ~wr_lat;
    assign strobe      = cpu_rd | rd_lat | cpu_wr | wr_lat;
    assign cpu_rd_data = word_shuffle_rd(cpu_addr[0], data);
    assign unused_addr = ^cpu_addr[19:1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rd_lat     <= 1'b0;
            wr_lat     <= 1'b0;
            paused     <= 1'b0;
            rq_active  <= 1'b0;
            sdr_rq     <= 1'b0;
            sdr_addr   <= '0;
            sdr_din    <= '0;
            sdr_wr_sel <= 2'b00;
            data       <= '0;
            pause_v    <= '0;
            pause_h    <= '0;
        end else begin
            rd_lat <= cpu_rd;
            wr_lat <= cpu_wr;
            case (state)
                IDLE: begin
                    if ((launch_rd | launch_wr) & region_memrq) begin
                        state     <= REQ;
                        sdr_addr  <= region_addr;
                        sdr_rq    <= ~sdr_rq;
                        rq_active <= 1'b1;
                        // Writes to read-only space still complete as a read so the CPU never hangs
                        if (launch_wr & region_writable) begin
                            sdr_wr_sel <= byte_sel(cpu_addr[0], cpu_be);
                            sdr_din    <= word_shuffle_wr(cpu_addr[0], cpu_dout);
                        end else begin
                            sdr_wr_sel <= 2'b00;
                        end
                    end else if (pause_rq & ~strobe & ~rq_active) begin
                        state   <= PAUSED;
                        pause_v <= v_count;
                        pause_h <= h_count;
                        paused  <= 1'b1;
                    end
                end
                REQ: begin
                    if (sdr_ack == sdr_rq) begin
                        state     <= IDLE;
                        data      <= sdr_dout;
                        rq_active <= 1'b0;
                    end
                end
                PAUSED: begin
                    if (~pause_rq && v_count == pause_v && h_count == pause_h) begin
                        state  <= IDLE;
                        paused <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    m92_ce_gate #(.CE_DIV(CE_DIV)) u_ce_gate (
        .clk        (clk),
        .reset      (reset),
        .mem_strobe (region_memrq & strobe),
        .rq_active  (rq_active),
        .ext_busy   (ext_busy),
        .paused_st  (state == PAUSED),
        .ce_cpu     (ce_cpu),
        .ce_4x_cpu  (ce_4x_cpu)
    );

endmodule

// File: tb/tb_m92_cpu_bus_ctrl.sv
// Bench for m92_cpu_bus_ctrl: directed scenarios then random bus traffic, all
// checked each cycle against a transaction-level model of the bus controller.
module tb_m92_cpu_bus_ctrl;

    localparam int AW  = 25;
    localparam int DIV = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          pause_rq = 1'b0;
    logic [8:0]    v_count = '0;
    logic [9:0]    h_count = '0;
    logic          paused;
    logic          cpu_rd = 1'b0, cpu_wr = 1'b0;
    logic [19:0]   cpu_addr = '0;
    logic [1:0]    cpu_be = '0;
    logic [15:0]   cpu_dout = '0;
    logic [15:0]   cpu_rd_data;
    logic          region_memrq = 1'b0;
    logic [AW-1:0] region_addr = '0;
    logic          region_writable = 1'b0;
    logic          ext_busy = 1'b0;
    logic          ce_cpu, ce_4x_cpu, rq_active, sdr_rq;
    logic          sdr_ack = 1'b0;
    logic [AW-1:0] sdr_addr;
    logic [15:0]   sdr_din;
    logic [1:0]    sdr_wr_sel;
    logic [15:0]   sdr_dout = '0;

    m92_cpu_bus_ctrl #(.CE_DIV(DIV), .SDR_AW(AW)) dut (
        .clk(clk), .reset(reset), .pause_rq(pause_rq), .v_count(v_count), .h_count(h_count),
        .paused(paused), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_be(cpu_be),
        .cpu_dout(cpu_dout), .cpu_rd_data(cpu_rd_data), .region_memrq(region_memrq),
        .region_addr(region_addr), .region_writable(region_writable), .ext_busy(ext_busy),
        .ce_cpu(ce_cpu), .ce_4x_cpu(ce_4x_cpu), .rq_active(rq_active), .sdr_rq(sdr_rq),
        .sdr_ack(sdr_ack), .sdr_addr(sdr_addr), .sdr_din(sdr_din), .sdr_wr_sel(sdr_wr_sel),
        .sdr_dout(sdr_dout)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: outstanding request / paused flags plus the values the bus should present
    bit            m_busy, m_paused, m_rq, m_ce4, m_ce, m_rd_prev, m_wr_prev;
    logic [AW-1:0] m_addr;
    logic [1:0]    m_sel;
    logic [15:0]   m_din, m_data;
    logic [8:0]    m_pv;
    logic [9:0]    m_ph;
    int            m_ticks;

    // SDRAM responder
    bit          rand_mode = 0;
    int          resp_lat = 7;
    logic [15:0] resp_data = '0;
    int          pend = 0, pend_target = 0;
    bit          obs_ce4;

    task automatic model_clear();
        m_busy = 0; m_paused = 0; m_rq = 0; m_ce4 = 0; m_ce = 0;
        m_rd_prev = 0; m_wr_prev = 0; m_addr = '0; m_sel = '0; m_din = '0;
        m_data = '0; m_pv = '0; m_ph = '0; m_ticks = 0;
    endtask

    task automatic model_next();
        bit strobe, new_rd, new_wr, stall;
        strobe = cpu_rd || cpu_wr || m_rd_prev || m_wr_prev;
        new_rd = cpu_rd && !m_rd_prev;
        new_wr = cpu_wr && !m_wr_prev;
        stall  = (region_memrq && strobe) || m_busy || ext_busy || m_paused;
        m_ce4  = !stall;
        m_ce   = !stall && (m_ticks % DIV == DIV - 1);
        if (!stall) m_ticks++;
        if (m_busy) begin
            if (sdr_ack == m_rq) begin
                m_busy = 0;
                m_data = sdr_dout;
            end
        end else if (m_paused) begin
            if (!pause_rq && v_count == m_pv && h_count == m_ph) m_paused = 0;
        end else if ((new_rd || new_wr) && region_memrq) begin
            m_busy = 1;
            m_rq   = !m_rq;
            m_addr = region_addr;
            if (new_wr && region_writable) begin
                m_sel = cpu_addr[0] ? 2'((cpu_be & 2'b01) << 1) : cpu_be;
                m_din = cpu_addr[0] ? 16'(cpu_dout << 8) : cpu_dout;
            end else begin
                m_sel = 2'b00;
            end
        end else if (pause_rq && !strobe) begin
            m_paused = 1;
            m_pv = v_count;
            m_ph = h_count;
        end
        m_rd_prev = cpu_rd;
        m_wr_prev = cpu_wr;
    endtask

    task automatic step();
        if (sdr_rq !== sdr_ack) begin
            if (pend == 0) pend_target = rand_mode ? int'($urandom_range(1, 10)) : resp_lat;
            pend++;
            if (pend >= pend_target) begin
                sdr_ack  = sdr_rq;
                sdr_dout = rand_mode ? 16'($urandom) : resp_data;
                pend = 0;
            end
        end
        @(negedge clk);
        obs_ce4 = ce_4x_cpu;
        chk("ce_4x", ce_4x_cpu, m_ce4);
        chk("ce", ce_cpu, m_ce);
        chk("rq_active", rq_active, m_busy);
        chk("paused", paused, m_paused);
        chk("sdr_rq", sdr_rq, m_rq);
        chk("sdr_addr", sdr_addr, m_addr);
        chk("wr_sel", sdr_wr_sel, m_sel);
        if (m_sel != 2'b00) chk("sdr_din", sdr_din, m_din);
        chk("rd_data", cpu_rd_data, cpu_addr[0] ? (m_data >> 8) : m_data);
        model_next();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        cpu_rd = 0; cpu_wr = 0;
        reset = 1'b1;
        sdr_ack = 1'b0;
        pend = 0;
        model_clear();
        repeat (2) begin
            @(negedge clk);
            chk("rst_ce4", ce_4x_cpu, 0);
            chk("rst_ce", ce_cpu, 0);
            chk("rst_rq_active", rq_active, 0);
            chk("rst_paused", paused, 0);
            chk("rst_sdr_rq", sdr_rq, 0);
            chk("rst_sdr_addr", sdr_addr, 0);
            chk("rst_wr_sel", sdr_wr_sel, 0);
            chk("rst_sdr_din", sdr_din, 0);
            chk("rst_rd_data", cpu_rd_data, 0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // One CPU access; ce_sum counts ce_4x pulses from the launch cycle to the cycle after ack
    task automatic cpu_access(input bit wr, input logic [19:0] a, input logic [1:0] be,
                              input logic [15:0] d, input bit wrt, input logic [AW-1:0] ra,
                              output int ce_sum);
        int n;
        cpu_addr = a; cpu_be = be; cpu_dout = d;
        region_memrq = 1'b1; region_writable = wrt; region_addr = ra;
        if (wr) cpu_wr = 1'b1; else cpu_rd = 1'b1;
        step();
        cpu_rd = 1'b0; cpu_wr = 1'b0;
        ce_sum = 0;
        n = 0;
        while (m_busy && n < 200) begin
            step();
            ce_sum += int'(obs_ce4);
            n++;
        end
        chk("req_in_budget", n < 200, 1);
        step();
        ce_sum += int'(obs_ce4);
    endtask

    initial begin
        int   ce_sum;
        logic rq_before;

        #2;
        apply_reset();
        repeat (6) step();

        // 1: even ROM read, ack after 7 cycles
        resp_lat = 7; resp_data = 16'hA55A;
        rq_before = sdr_rq;
        cpu_access(0, 20'h00100, 2'b11, 16'h0000, 0, 25'h0000080, ce_sum);
        chk("t1_wr_sel", sdr_wr_sel, 2'b00);
        chk("t1_rq_toggled", sdr_rq, !rq_before);
        chk("t1_no_ce", ce_sum, 0);
        chk("t1_rd_data", cpu_rd_data, 16'hA55A);

        // 2: odd byte write to writable RAM
        resp_lat = 3; resp_data = 16'h0000;
        cpu_access(1, 20'hE0001, 2'b01, 16'h0034, 1, 25'h0070000, ce_sum);
        chk("t2_wr_sel", sdr_wr_sel, 2'b10);
        chk("t2_din", sdr_din, 16'h3400);
        chk("t2_no_ce", ce_sum, 0);

        // 3: same write into read-only space
        cpu_access(1, 20'hE0001, 2'b01, 16'h0034, 0, 25'h0070000, ce_sum);
        chk("t3_wr_sel", sdr_wr_sel, 2'b00);
        chk("t3_done", rq_active, 0);
        chk("t3_ce_resumed", ce_4x_cpu, 1);

        // 4: odd read
        resp_lat = 2; resp_data = 16'h1234;
        cpu_access(0, 20'h00201, 2'b11, 16'h0000, 0, 25'h0000100, ce_sum);
        chk("t4_rd_data", cpu_rd_data, 16'h0012);
        repeat (3) step();

        // 5: frame-exact pause/resume
        v_count = 9'd100; h_count = 10'd200; pause_rq = 1'b1;
        step();
        step();
        chk("t5_paused", paused, 1);
        v_count = 9'd50; h_count = 10'd0; pause_rq = 1'b0;
        repeat (5) step();
        chk("t5_hold_v50", paused, 1);
        chk("t5_no_ce_paused", ce_4x_cpu, 0);
        v_count = 9'd100; h_count = 10'd200; pause_rq = 1'b1;
        step();
        chk("t5_rq_reassert", paused, 1);
        pause_rq = 1'b0;
        step();
        chk("t5_released", paused, 0);
        step();
        chk("t5_ce_resume", ce_4x_cpu, 1);

        // 5b: pause requested during an outstanding read
        resp_lat = 5; resp_data = 16'hBEEF;
        pause_rq = 1'b1;
        cpu_access(0, 20'h00300, 2'b11, 16'h0000, 0, 25'h0000180, ce_sum);
        chk("t5b_no_ce", ce_sum, 0);
        chk("t5b_pause_after_ack", paused, 1);
        pause_rq = 1'b0;
        step();
        step();
        chk("t5b_released", paused, 0);

        // 6: reset while a request is outstanding
        resp_lat = 20;
        cpu_addr = 20'h00400; region_addr = 25'h0000200; region_memrq = 1'b1; cpu_rd = 1'b1;
        step();
        cpu_rd = 1'b0;
        repeat (3) step();
        chk("t6_inflight", rq_active, 1);
        apply_reset();
        resp_lat = 4; resp_data = 16'h5AA5;
        cpu_access(0, 20'h00400, 2'b11, 16'h0000, 0, 25'h0000200, ce_sum);
        chk("t6_rq_after_reset", sdr_rq, 1);
        chk("t6_rd_data", cpu_rd_data, 16'h5AA5);

        // 6b: external stall for 10 cycles
        step();
        ext_busy = 1'b1;
        step();
        ce_sum = 0;
        repeat (9) begin
            step();
            ce_sum += int'(obs_ce4);
        end
        ext_busy = 1'b0;
        step();
        ce_sum += int'(obs_ce4);
        chk("t6b_ext_busy_no_ce", ce_sum, 0);

        // Random traffic against the model
        rand_mode = 1;
        v_count = '0; h_count = '0;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) apply_reset();
            cpu_rd          = !cpu_rd && ($urandom_range(0, 7) == 0);
            cpu_wr          = !cpu_wr && ($urandom_range(0, 9) == 0);
            cpu_addr        = 20'($urandom);
            cpu_be          = 2'($urandom);
            cpu_dout        = 16'($urandom);
            region_memrq    = $urandom_range(0, 3) != 0;
            region_writable = 1'($urandom);
            region_addr     = AW'($urandom);
            ext_busy        = $urandom_range(0, 9) == 0;
            if ($urandom_range(0, 79) == 0) pause_rq = !pause_rq;
            h_count = (h_count == 10'd15) ? 10'd0 : h_count + 10'd1;
            if (h_count == 10'd0) v_count = (v_count == 9'd7) ? 9'd0 : v_count + 9'd1;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
